// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture sequencer and its post-trigger counter.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TRIG,
        POST,
        DONE
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/capture_sequencer_sample_counter.sv
// Post-trigger sample counter: load clears the count and latches the target,
// enable advances the count, which saturates at the target instead of wrapping.
module sample_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             enable_i,
    output logic             tc_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + 1'b1;
    assign tc_o      = (count_q == target_q);
    // Widened compare so the final step toward a full-scale target cannot alias to zero.
    assign last_o    = !tc_o && (count_inc == {1'b0, target_q});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            target_q <= '0;
        end else if (load_i) begin
            count_q  <= '0;
            target_q <= load_value_i;
        end else if (enable_i && !tc_o) begin
            count_q  <= count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms the sampler, waits for its trigger and forwards cfg_post samples
// to a FIFO. Define CAPTURE_TIMEOUT_EN to build the trigger-wait watchdog.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int SAMPLE_W       = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                system_clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    cfg_post,
    output logic                arm,
    input  logic                sampler_run,
    input  logic                sampler_valid,
    input  logic [SAMPLE_W-1:0] sampler_data,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [SAMPLE_W-1:0] fifo_wr_data,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                timed_out
);

    state_e              state_q;
    logic                arm_q;
    logic                busy_q;
    logic                done_q;
    logic                overrun_q;
    logic                wr_en_q;
    logic [SAMPLE_W-1:0] wr_data_q;

    logic cnt_load;
    logic post_valid;
    logic cnt_tc;
    logic cnt_last;
    logic wd_expire;

    assign cnt_load   = (state_q == IDLE) && start && !abort;
    assign post_valid = (state_q == POST) && sampler_valid && !cnt_tc && !abort;

    sample_counter #(
        .CNT_W(CNT_W)
    ) u_sample_counter (
        .clk_i        (system_clock),
        .reset_i      (reset),
        .load_i       (cnt_load),
        .load_value_i (cfg_post),
        .enable_i     (post_valid),
        .tc_o         (cnt_tc),
        .last_o       (cnt_last)
    );

`ifdef CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            timed_out_q;

    assign wd_expire = (state_q == WAIT_TRIG) && !sampler_run && !abort
                       && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign timed_out = timed_out_q;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            wd_q        <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wd_q <= ((state_q == WAIT_TRIG) && !sampler_run) ? wd_q + 1'b1 : '0;
            if (cnt_load) begin
                timed_out_q <= 1'b0;
            end else if (wd_expire) begin
                timed_out_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            // NOTE: pulse defaults first; a later non-blocking assignment in this block wins.
            arm_q   <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q   <= ARM;
                        arm_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                    end
                    ARM: state_q <= WAIT_TRIG;
                    WAIT_TRIG: begin
                        if (sampler_run) begin
                            state_q <= POST;
                        end else if (wd_expire) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    POST: begin
                        if (post_valid) begin
                            if (fifo_full) begin
                                overrun_q <= 1'b1;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= sampler_data;
                            end
                        end
                        // Finish on the cycle the last sample is consumed (or at once for cfg_post=0).
                        if (cnt_tc || (post_valid && cnt_last)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign arm          = arm_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: directed scenarios push expected FIFO writes,
// an independent monitor pops and compares them on every fifo_wr_en.
module tb_capture_sequencer;

    localparam int SAMPLE_W = 8;
    localparam int CNT_W    = 16;

    logic                system_clock = 1'b0;
    logic                reset        = 1'b1;
    logic                start        = 1'b0;
    logic                abort        = 1'b0;
    logic [CNT_W-1:0]    cfg_post     = '0;
    logic                arm;
    logic                sampler_run   = 1'b0;
    logic                sampler_valid = 1'b0;
    logic [SAMPLE_W-1:0] sampler_data  = '0;
    logic                fifo_full     = 1'b0;
    logic                fifo_wr_en;
    logic [SAMPLE_W-1:0] fifo_wr_data;
    logic                busy;
    logic                done;
    logic                overrun;
    logic                timed_out;

    int tests     = 0;
    int fails     = 0;
    int done_seen = 0;
    int done_exp  = 0;
    logic [SAMPLE_W-1:0] exp_q[$];

    always #5 system_clock = ~system_clock;

    capture_sequencer #(
        .SAMPLE_W       (SAMPLE_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .system_clock  (system_clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_post      (cfg_post),
        .arm           (arm),
        .sampler_run   (sampler_run),
        .sampler_valid (sampler_valid),
        .sampler_data  (sampler_data),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .timed_out     (timed_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the oldest expected sample.
    initial begin
        forever begin
            @(negedge system_clock);
            if (done) done_seen++;
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got data 0x%0h, expected no write", fifo_wr_data);
                end else begin
                    check("wr_data", fifo_wr_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge system_clock);
        #1;
        start         = 1'b0;
        abort         = 1'b0;
        sampler_valid = 1'b0;
    endtask

    task automatic start_capture(input logic [CNT_W-1:0] cfg);
        cfg_post = cfg;
        start    = 1'b1;
        step();
        check("arm_pulse", arm, 1);
        check("busy_arm", busy, 1);
        step();
        check("arm_low_wait", arm, 0);
        check("busy_wait", busy, 1);
    endtask

    task automatic trigger();
        sampler_run = 1'b1;
        step();
        sampler_run = 1'b0;
        check("busy_post", busy, 1);
    endtask

    task automatic sample(input logic [SAMPLE_W-1:0] data, input logic full, input logic exp_wr);
        sampler_valid = 1'b1;
        sampler_data  = data;
        fifo_full     = full;
        if (exp_wr) exp_q.push_back(data);
        step();
        fifo_full = 1'b0;
        check("wr_en_timing", fifo_wr_en, exp_wr);
    endtask

    initial begin
        // Reset state.
        step();
        step();
        check("rst_arm", arm, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timed_out", timed_out, 0);
        reset = 1'b0;
        step();

        // Four-sample capture, trigger three cycles after arm.
        start_capture(16'd4);
        step();
        check("wait_no_done", done, 0);
        trigger();
        for (int i = 0; i < 4; i++) begin
            sample(8'h11 + 8'(i), 1'b0, 1'b1);
            check("done_early", done, (i == 3) ? 1 : 0);
        end
        done_exp++;
        check("busy_after_done", busy, 0);
        step();
        check("done_one_cycle", done, 0);
        check("no_write_after_done", fifo_wr_en, 0);
        check("queue_drained_a", exp_q.size(), 0);

        // Second sample dropped on fifo_full.
        start_capture(16'd3);
        trigger();
        sample(8'h21, 1'b0, 1'b1);
        sample(8'h22, 1'b1, 1'b0);
        check("overrun_set", overrun, 1);
        sample(8'h23, 1'b0, 1'b1);
        check("done_overrun", done, 1);
        done_exp++;
        step();
        check("overrun_sticky", overrun, 1);

        // Abort after two of five samples.
        start_capture(16'd5);
        check("overrun_cleared", overrun, 0);
        trigger();
        sample(8'h31, 1'b0, 1'b1);
        sample(8'h32, 1'b0, 1'b1);
        abort = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_en", fifo_wr_en, 0);
        sampler_run = 1'b1;
        sample(8'h33, 1'b0, 1'b0);
        sample(8'h34, 1'b0, 1'b0);
        sampler_run = 1'b0;
        check("abort_idle_arm", arm, 0);
        check("abort_idle_busy", busy, 0);

        // start while waiting for trigger is ignored.
        start_capture(16'd1);
        start = 1'b1;
        step();
        check("restart_no_arm", arm, 0);
        check("restart_busy", busy, 1);
        trigger();
        sample(8'h41, 1'b0, 1'b1);
        check("done_single", done, 1);
        done_exp++;
        step();

        // cfg_post = 0: done with no writes.
        start_capture(16'd0);
        trigger();
        check("zero_no_done_yet", done, 0);
        step();
        check("zero_done", done, 1);
        check("zero_no_write", fifo_wr_en, 0);
        done_exp++;
        step();

        // Reset in POST beats every other input and discards the pending write.
        start_capture(16'd4);
        trigger();
        sample(8'h51, 1'b1, 1'b0);
        check("overrun_before_reset", overrun, 1);
        reset         = 1'b1;
        start         = 1'b1;
        abort         = 1'b1;
        sampler_valid = 1'b1;
        sampler_data  = 8'h52;
        step();
        reset = 1'b0;
        check("post_rst_arm", arm, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_wr_en", fifo_wr_en, 0);
        check("post_rst_wr_data", fifo_wr_data, 0);
        check("post_rst_overrun", overrun, 0);
        step();

        // Trigger never arrives.
        start_capture(16'd2);
`ifdef CAPTURE_TIMEOUT_EN
        for (int i = 0; i < 9; i++) begin
            step();
            check("wd_no_done", done, 0);
        end
        step();
        check("wd_done", done, 1);
        check("wd_timed_out", timed_out, 1);
        done_exp++;
        step();
        check("wd_sticky", timed_out, 1);
        check("wd_idle", busy, 0);
        start_capture(16'd0);
        check("wd_cleared", timed_out, 0);
        abort = 1'b1;
        step();
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check("wait_forever_busy", busy, 1);
            check("wait_forever_done", done, 0);
        end
        check("no_wd_timed_out", timed_out, 0);
        abort = 1'b1;
        step();
        check("abort_wait_busy", busy, 0);
`endif

        step();
        step();
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, meaning sample bus width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning post-trigger sample counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning trigger-wait watchdog limit; used only with CAPTURE_TIMEOUT_EN.
REQ-004 SHALL have port system_clock, input, 1, the single clock; all logic uses its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle capture request.
REQ-007 SHALL have port abort, input, 1, cancels any capture.
REQ-008 SHALL have port cfg_post, input, CNT_W, number of samples to store after the trigger.
REQ-009 SHALL have port arm, output, 1, one-cycle arm pulse to the sampler.
REQ-010 SHALL have port sampler_run, input, 1, sampler trigger-fired/running indication.
REQ-011 SHALL have port sampler_valid, input, 1, sampler data strobe.
REQ-012 SHALL have port sampler_data, input, SAMPLE_W, sampler output data.
REQ-013 SHALL have port fifo_full, input, 1, downstream FIFO full.
REQ-014 SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-015 SHALL have port fifo_wr_data, output, SAMPLE_W, FIFO write data.
REQ-016 SHALL have port busy, output, 1, high in ARM, WAIT_TRIG and POST.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port overrun, output, 1, sticky flag for samples dropped on fifo_full.
REQ-019 SHALL have port timed_out, output, 1, sticky flag for watchdog expiry.

Function
REQ-020 FSM states SHALL be IDLE, ARM, WAIT_TRIG, POST, DONE.
REQ-021 IDLE -> ARM on start; cfg_post latched that cycle; overrun and timed_out cleared.
REQ-022 ARM SHALL assert arm for exactly one cycle, then go to WAIT_TRIG.
REQ-023 WAIT_TRIG -> POST on the first cycle sampler_run is high; no FIFO writes occur in WAIT_TRIG.
REQ-024 POST: each sampler_valid consumes one count; fifo_wr_en and fifo_wr_data are registered one cycle after sampler_valid/sampler_data.
REQ-025 POST -> DONE when the count reaches the latched cfg_post; cfg_post=0 SHALL go WAIT_TRIG -> POST -> DONE with zero writes.
REQ-026 sampler_valid while fifo_full in POST: sample dropped, no write, overrun set, count still consumed.
REQ-027 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-028 start while not IDLE SHALL be ignored.
REQ-029 abort SHALL force IDLE next cycle from any state: no done pulse, no further writes, arm low; abort overrides start in the same cycle.
REQ-030 Counter SHALL be CNT_W bits and SHALL not wrap; cfg_post = 2^CNT_W-1 is the maximum capture.

Reset
REQ-031 On reset: state IDLE, counter 0, arm/fifo_wr_en/busy/done/overrun/timed_out = 0, fifo_wr_data = 0.
REQ-032 Reset mid-capture SHALL take priority over start, abort and sampler inputs and discard any pending registered write.

Configuration
REQ-033 With CAPTURE_TIMEOUT_EN defined, WAIT_TRIG SHALL count cycles; after TIMEOUT_CYCLES without sampler_run it SHALL set timed_out and go to DONE (done pulses).
REQ-034 Without CAPTURE_TIMEOUT_EN, no watchdog logic is built, WAIT_TRIG waits indefinitely, and timed_out is tied 0.

Structure
REQ-035 State enum and the TIMEOUT_CYCLES default SHALL reside in the shared package capture_pkg.
REQ-036 The post-trigger counter SHALL be a sub-module sample_counter (load, enable, terminal-count output); the FSM stays in capture_sequencer.

Verification
REQ-037 cfg_post=4, start, sampler_run high 3 cycles after arm, 4 valids (0x11..0x14) -> 4 writes of 0x11..0x14, each 1 cycle late, done 1 cycle after last count.
REQ-038 cfg_post=3, fifo_full high during 2nd valid -> writes of 1st and 3rd samples only, overrun=1, done pulses.
REQ-039 abort during POST after 2 of 5 samples -> IDLE next cycle, no done, no further fifo_wr_en.
REQ-040 start pulsed in WAIT_TRIG -> no second arm pulse, state unchanged.
REQ-041 CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=10, sampler_run held low -> timed_out=1 and done after 10 WAIT_TRIG cycles; without macro stays in WAIT_TRIG.
REQ-042 cfg_post=0 -> done pulse after trigger with zero writes; reset asserted in POST -> all outputs 0 next cycle.
